// File: rtl/ecc_scrub_ctrl.sv
// Background scrubber for a SECDED-protected TCDM bank.
// Periodically reads one word, lets the external decoder check it, and writes
// corrected data back on a single-bit error. The host keeps the port except
// during the scrub read and write-back cycles; a persistently busy host is
// pre-empted after STALL_LIMIT blocked cycles so scrubbing always progresses.
module ecc_scrub_ctrl #(
  parameter int BANK_SIZE      = 256,
  parameter int SCRUB_INTERVAL = 1024,
  parameter int STALL_LIMIT    = 16,
  localparam int AW            = $clog2(BANK_SIZE)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          scrub_en_i,
  input  logic          host_req_i,
  input  logic          host_we_i,
  input  logic [AW-1:0] host_add_i,
  output logic          host_gnt_o,
  output logic          bank_req_o,
  output logic          bank_we_o,
  output logic [AW-1:0] bank_add_o,
  output logic          scrub_sel_o,
  output logic [31:0]   scrub_wdata_o,
  input  logic [31:0]   dec_data_i,
  input  logic [1:0]    dec_err_i,
  output logic [15:0]   corr_cnt_o,
  output logic [15:0]   uncorr_cnt_o,
  output logic          uncorr_o,
  output logic [AW-1:0] uncorr_add_o
);

  localparam int IW = $clog2(SCRUB_INTERVAL);
  localparam int SW = $clog2(STALL_LIMIT + 1);

  localparam logic [IW-1:0] INTV_RELOAD = IW'(SCRUB_INTERVAL - 1);
  localparam logic [SW-1:0] STALL_MAX   = SW'(STALL_LIMIT);
  localparam logic [AW-1:0] ADDR_LAST   = AW'(BANK_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CHECK = 2'd2,
    WRITE = 2'd3
  } state_e;

  state_e        state_q;
  state_e        state_d;
  logic [IW-1:0] intv_q;
  logic [SW-1:0] stall_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [15:0]   corr_cnt_q;
  logic [15:0]   uncorr_cnt_q;
  logic          uncorr_q;
  logic [AW-1:0] uncorr_add_q;

  logic          scrub_rd;
  logic          adv_addr;
  logic          stall_hit;
  logic          host_wr_hit;
  logic          leave_seq;

  // Saturating 16-bit increment for the error counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Wrapping increment of the scrub address over a possibly non-power-of-two bank.
  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == ADDR_LAST) ? '0 : a + AW'(1);
  endfunction

  assign stall_hit   = (stall_q == STALL_MAX);
  assign host_wr_hit = host_req_i & host_we_i & (host_add_i == addr_q);
  assign leave_seq   = (state_q == CHECK) || (state_q == WRITE);

  // Next-state decode and port mux; the host owns the port unless overridden.
  always_comb begin
    state_d     = state_q;
    scrub_rd    = 1'b0;
    adv_addr    = 1'b0;
    host_gnt_o  = 1'b1;
    bank_req_o  = host_req_i;
    bank_we_o   = host_we_i;
    bank_add_o  = host_add_i;
    scrub_sel_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (scrub_en_i && (intv_q == '0)) begin
          state_d = READ;
        end
      end
      READ: begin
        // Take the port when the host is quiet or has blocked us too long.
        if (!host_req_i || stall_hit) begin
          scrub_rd   = 1'b1;
          host_gnt_o = 1'b0;
          bank_req_o = 1'b1;
          bank_we_o  = 1'b0;
          bank_add_o = addr_q;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        // A host write to the same word supersedes the stale corrected data.
        if (dec_err_i[1]) begin
          state_d  = IDLE;
          adv_addr = 1'b1;
        end else if (dec_err_i[0] && !host_wr_hit) begin
          state_d = WRITE;
        end else begin
          state_d  = IDLE;
          adv_addr = 1'b1;
        end
      end
      WRITE: begin
        host_gnt_o  = 1'b0;
        bank_req_o  = 1'b1;
        bank_we_o   = 1'b1;
        bank_add_o  = addr_q;
        scrub_sel_o = 1'b1;
        state_d     = IDLE;
        adv_addr    = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Interval counter: counts down idle cycles between scrub starts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      intv_q <= INTV_RELOAD;
    end else if (!scrub_en_i || leave_seq) begin
      intv_q <= INTV_RELOAD;
    end else if ((state_q == IDLE) && (intv_q != '0)) begin
      intv_q <= intv_q - IW'(1);
    end
  end

  // Stall counter: consecutive READ cycles lost to the host.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (scrub_rd) begin
      stall_q <= '0;
    end else if (state_q == READ) begin
      stall_q <= stall_q + SW'(1);
    end
  end

  // Scrub address pointer, advanced once per completed scrub.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
    end else if (adv_addr) begin
      addr_q <= addr_inc(addr_q);
    end
  end

  // Capture decoder output while checking; it feeds the write-back encoder.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdata_q <= '0;
    end else if (state_q == CHECK) begin
      wdata_q <= dec_data_i;
    end
  end

  // Error statistics and the uncorrectable-error report.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
      uncorr_q     <= 1'b0;
      uncorr_add_q <= '0;
    end else begin
      uncorr_q <= 1'b0;
      if (state_q == CHECK) begin
        if (dec_err_i[1]) begin
          uncorr_q     <= 1'b1;
          uncorr_add_q <= addr_q;
          uncorr_cnt_q <= sat_inc(uncorr_cnt_q);
        end else if (dec_err_i[0]) begin
          corr_cnt_q <= sat_inc(corr_cnt_q);
        end
      end
    end
  end

  assign scrub_wdata_o = wdata_q;
  assign corr_cnt_o    = corr_cnt_q;
  assign uncorr_cnt_o  = uncorr_cnt_q;
  assign uncorr_o      = uncorr_q;
  assign uncorr_add_o  = uncorr_add_q;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Bench for ecc_scrub_ctrl: directed scenarios plus random traffic, every
// cycle compared against a behavioural model of the scrubber.
module tb_ecc_scrub_ctrl;

  localparam int BANK  = 256;
  localparam int INTV  = 4;
  localparam int STALL = 3;

  localparam int PH_WAIT = 0;
  localparam int PH_RD   = 1;
  localparam int PH_CHK  = 2;
  localparam int PH_WB   = 3;

  logic        clk;
  logic        rst;
  logic        scrub_en;
  logic        host_req;
  logic        host_we;
  logic [7:0]  host_add;
  logic        host_gnt;
  logic        bank_req;
  logic        bank_we;
  logic [7:0]  bank_add;
  logic        scrub_sel;
  logic [31:0] scrub_wdata;
  logic [31:0] dec_data;
  logic [1:0]  dec_err;
  logic [15:0] corr_cnt;
  logic [15:0] uncorr_cnt;
  logic        uncorr;
  logic [7:0]  uncorr_add;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int          m_ph;
  int          m_cnt;
  int          m_stall;
  int          m_addr;
  int          m_corr;
  int          m_uncorr;
  int          m_upulse;
  int          m_uadd;
  logic [31:0] m_wdata;
  int          last_ph;

  int   gq[$];
  int   nreads;
  int   sav_addr;
  int   sav_corr;
  logic [1:0] rerr;
  int   rv;

  ecc_scrub_ctrl #(
    .BANK_SIZE     (BANK),
    .SCRUB_INTERVAL(INTV),
    .STALL_LIMIT   (STALL)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .scrub_en_i   (scrub_en),
    .host_req_i   (host_req),
    .host_we_i    (host_we),
    .host_add_i   (host_add),
    .host_gnt_o   (host_gnt),
    .bank_req_o   (bank_req),
    .bank_we_o    (bank_we),
    .bank_add_o   (bank_add),
    .scrub_sel_o  (scrub_sel),
    .scrub_wdata_o(scrub_wdata),
    .dec_data_i   (dec_data),
    .dec_err_i    (dec_err),
    .corr_cnt_o   (corr_cnt),
    .uncorr_cnt_o (uncorr_cnt),
    .uncorr_o     (uncorr),
    .uncorr_add_o (uncorr_add)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_reset();
    m_ph     = PH_WAIT;
    m_cnt    = INTV - 1;
    m_stall  = 0;
    m_addr   = 0;
    m_corr   = 0;
    m_uncorr = 0;
    m_upulse = 0;
    m_uadd   = 0;
    m_wdata  = 32'h0;
  endtask

  // Expected outputs for the current cycle from model state and inputs.
  task automatic check_outputs(input logic hq, input logic hw, input logic [7:0] ha);
    logic [3:0] e_ctl;
    logic [7:0] e_add;
    if (m_ph == PH_RD && (!hq || m_stall == STALL)) begin
      e_ctl = 4'b0100;
      e_add = 8'(m_addr);
    end else if (m_ph == PH_WB) begin
      e_ctl = 4'b0111;
      e_add = 8'(m_addr);
    end else begin
      e_ctl = {1'b1, hq, hw, 1'b0};
      e_add = ha;
    end
    checks++;
    assert ({host_gnt, bank_req, bank_we, scrub_sel} === e_ctl) else begin
      errors++;
      $error("FAIL port_ctl got=%b exp=%b", {host_gnt, bank_req, bank_we, scrub_sel}, e_ctl);
    end
    checks++;
    assert (bank_add === e_add) else begin
      errors++;
      $error("FAIL bank_add got=%0d exp=%0d", bank_add, e_add);
    end
    checks++;
    assert (scrub_wdata === m_wdata) else begin
      errors++;
      $error("FAIL wdata got=%h exp=%h", scrub_wdata, m_wdata);
    end
    checks++;
    assert (corr_cnt === 16'(m_corr)) else begin
      errors++;
      $error("FAIL corr_cnt got=%0d exp=%0d", corr_cnt, m_corr);
    end
    checks++;
    assert (uncorr_cnt === 16'(m_uncorr)) else begin
      errors++;
      $error("FAIL uncorr_cnt got=%0d exp=%0d", uncorr_cnt, m_uncorr);
    end
    checks++;
    assert ({uncorr, uncorr_add} === {1'(m_upulse), 8'(m_uadd)}) else begin
      errors++;
      $error("FAIL uncorr_rep got=%b/%0d exp=%0d/%0d", uncorr, uncorr_add, m_upulse, m_uadd);
    end
  endtask

  // Advance the model by one clock according to the scrubbing rules.
  task automatic model_update(input logic r, input logic en, input logic hq, input logic hw,
                              input logic [7:0] ha, input logic [1:0] de, input logic [31:0] dd);
    int  nph;
    bit  done;
    if (r) begin
      model_reset();
    end else begin
      nph      = m_ph;
      done     = 0;
      m_upulse = 0;
      if (m_ph == PH_WAIT) begin
        if (en && m_cnt == 0) nph = PH_RD;
      end else if (m_ph == PH_RD) begin
        if (!hq || m_stall == STALL) begin
          nph     = PH_CHK;
          m_stall = 0;
        end else begin
          m_stall = m_stall + 1;
        end
      end else if (m_ph == PH_CHK) begin
        m_wdata = dd;
        if (de[1]) begin
          m_upulse = 1;
          m_uadd   = m_addr;
          m_uncorr = sat16(m_uncorr);
          nph      = PH_WAIT;
          done     = 1;
        end else if (de[0]) begin
          m_corr = sat16(m_corr);
          if (hq && hw && (int'(ha) == m_addr)) begin
            nph  = PH_WAIT;
            done = 1;
          end else begin
            nph = PH_WB;
          end
        end else begin
          nph  = PH_WAIT;
          done = 1;
        end
      end else begin
        nph  = PH_WAIT;
        done = 1;
      end
      if (!en || m_ph == PH_CHK || m_ph == PH_WB) m_cnt = INTV - 1;
      else if (m_ph == PH_WAIT && m_cnt > 0) m_cnt = m_cnt - 1;
      if (done) m_addr = (m_addr + 1) % BANK;
      m_ph = nph;
    end
  endtask

  task automatic step(input logic r, input logic en, input logic hq, input logic hw,
                      input logic [7:0] ha, input logic [1:0] de, input logic [31:0] dd);
    @(negedge clk);
    rst      = r;
    scrub_en = en;
    host_req = hq;
    host_we  = hw;
    host_add = ha;
    dec_err  = de;
    dec_data = dd;
    #1;
    check_outputs(hq, hw, ha);
    last_ph = m_ph;
    model_update(r, en, hq, hw, ha, de, dd);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 32'h0);
  endtask

  // Run idle cycles until the model reaches a phase (and address, if addr >= 0).
  task automatic advance(input int ph, input int addr);
    bit reached;
    reached = 0;
    for (int i = 0; i < 80; i++) begin
      if (m_ph == ph && (addr < 0 || m_addr == addr)) begin
        reached = 1;
        break;
      end
      idle_step();
    end
    checks++;
    assert (reached === 1'b1) else begin
      errors++;
      $error("FAIL advance_timeout got_ph=%0d exp_ph=%0d", m_ph, ph);
    end
  endtask

  initial begin
    rst      = 1'b1;
    scrub_en = 1'b0;
    host_req = 1'b0;
    host_we  = 1'b0;
    host_add = 8'h00;
    dec_err  = 2'b00;
    dec_data = 32'h0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 32'h0);
    checks++;
    assert ({host_gnt, scrub_sel, uncorr, corr_cnt, uncorr_cnt, scrub_wdata} === {1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0}) else begin
      errors++;
      $error("FAIL reset_vals got gnt=%b sel=%b", host_gnt, scrub_sel);
    end

    // Idle host, no errors: one read every 6 cycles, address wraps
    nreads = 0;
    for (int k = 1; k <= 1600; k++) begin
      idle_step();
      if (bank_req === 1'b1) begin
        checks++;
        assert (bank_add === 8'(nreads % BANK)) else begin
          errors++;
          $error("FAIL read_addr got=%0d exp=%0d", bank_add, nreads % BANK);
        end
        checks++;
        assert (k === 5 + 6 * nreads) else begin
          errors++;
          $error("FAIL read_cycle got=%0d exp=%0d", k, 5 + 6 * nreads);
        end
        nreads++;
      end
    end
    checks++;
    assert (nreads > BANK) else begin
      errors++;
      $error("FAIL read_count got=%0d exp>%0d", nreads, BANK);
    end
    checks++;
    assert ({corr_cnt, uncorr_cnt} === 32'h0) else begin
      errors++;
      $error("FAIL idle_counts got=%0d/%0d exp=0/0", corr_cnt, uncorr_cnt);
    end

    // Single error: write-back of corrected data on the next cycle
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 32'h0);
    advance(PH_CHK, -1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'b01, 32'hDEADBEEF);
    idle_step();
    checks++;
    assert ({host_gnt, bank_req, bank_we, scrub_sel, bank_add} === {4'b0111, 8'd0}) else begin
      errors++;
      $error("FAIL wb_ctl got=%b/%0d exp=0111/0", {host_gnt, bank_req, bank_we, scrub_sel}, bank_add);
    end
    checks++;
    assert (scrub_wdata === 32'hDEADBEEF) else begin
      errors++;
      $error("FAIL wb_data got=%h exp=deadbeef", scrub_wdata);
    end
    checks++;
    assert (corr_cnt === 16'd1) else begin
      errors++;
      $error("FAIL wb_corr got=%0d exp=1", corr_cnt);
    end

    // Double error at address 5
    advance(PH_CHK, 5);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'b10, 32'h0BADF00D);
    idle_step();
    checks++;
    assert ({uncorr, uncorr_add, uncorr_cnt} === {1'b1, 8'd5, 16'd1}) else begin
      errors++;
      $error("FAIL uncorr_evt got=%b/%0d/%0d exp=1/5/1", uncorr, uncorr_add, uncorr_cnt);
    end
    checks++;
    assert ({bank_we, scrub_sel} === 2'b00) else begin
      errors++;
      $error("FAIL uncorr_nowb got=%b exp=00", {bank_we, scrub_sel});
    end
    idle_step();
    checks++;
    assert (uncorr === 1'b0) else begin
      errors++;
      $error("FAIL uncorr_pulse got=%b exp=0", uncorr);
    end

    // Host holds the port: granted STALL cycles, then pre-empted
    advance(PH_WAIT, -1);
    gq.delete();
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'($urandom), 2'b00, 32'h0);
      if (last_ph == PH_RD && gq.size() < 4) begin
        gq.push_back(int'(host_gnt));
        if (gq.size() == 4) begin
          checks++;
          assert ({bank_req, bank_we, bank_add} === {2'b10, 8'(m_addr)}) else begin
            errors++;
            $error("FAIL stall_rd got=%b/%0d exp=10/%0d", {bank_req, bank_we}, bank_add, m_addr);
          end
        end
      end
    end
    checks++;
    assert (gq.size() == 4 && gq[0] == 1 && gq[1] == 1 && gq[2] == 1 && gq[3] == 0) else begin
      errors++;
      $error("FAIL stall_gnt got=%p exp='{1,1,1,0}", gq);
    end

    // Host writes the scrub address during CHECK: write-back cancelled
    advance(PH_CHK, -1);
    sav_addr = m_addr;
    sav_corr = m_corr;
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'(m_addr), 2'b01, 32'h12345678);
    idle_step();
    checks++;
    assert ({bank_we, scrub_sel, corr_cnt} === {2'b00, 16'(sav_corr + 1)}) else begin
      errors++;
      $error("FAIL cancel_wb got=%b/%0d exp=00/%0d", {bank_we, scrub_sel}, corr_cnt, sav_corr + 1);
    end
    advance(PH_RD, -1);
    idle_step();
    checks++;
    assert (bank_add === 8'((sav_addr + 1) % BANK)) else begin
      errors++;
      $error("FAIL cancel_adv got=%0d exp=%0d", bank_add, (sav_addr + 1) % BANK);
    end

    // Counter saturation from a preloaded value
    idle_step();
    dut.corr_cnt_q   <= 16'hFFFE;
    dut.uncorr_cnt_q <= 16'hFFFF;
    m_corr   = 65534;
    m_uncorr = 65535;
    for (int n = 0; n < 2; n++) begin
      advance(PH_CHK, -1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'b01, 32'hA5A5A5A5);
      idle_step();
      checks++;
      assert (corr_cnt === 16'hFFFF) else begin
        errors++;
        $error("FAIL corr_sat got=%h exp=ffff", corr_cnt);
      end
    end
    advance(PH_CHK, -1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'b10, 32'h0);
    idle_step();
    checks++;
    assert ({uncorr, uncorr_cnt} === {1'b1, 16'hFFFF}) else begin
      errors++;
      $error("FAIL uncorr_sat got=%b/%h exp=1/ffff", uncorr, uncorr_cnt);
    end

    // Reset during CHECK with a pending single error: no write-back
    advance(PH_CHK, -1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'b01, 32'hCAFEF00D);
    idle_step();
    checks++;
    assert ({host_gnt, bank_req, bank_we, scrub_sel, uncorr} === 5'b10000) else begin
      errors++;
      $error("FAIL rst_chk_ctl got=%b exp=10000", {host_gnt, bank_req, bank_we, scrub_sel, uncorr});
    end
    checks++;
    assert ({corr_cnt, uncorr_cnt, scrub_wdata, uncorr_add} === 72'h0) else begin
      errors++;
      $error("FAIL rst_chk_regs got=%0d/%0d/%h/%0d exp=0", corr_cnt, uncorr_cnt, scrub_wdata, uncorr_add);
    end

    // Random traffic against the model
    for (int i = 0; i < 2500; i++) begin
      logic r, en, hq, hw;
      logic [7:0] ha;
      r  = ($urandom_range(399, 0) == 0);
      en = ($urandom_range(9, 0) != 0);
      hq = 1'($urandom);
      hw = 1'($urandom);
      ha = 8'($urandom);
      if (m_ph == PH_CHK && $urandom_range(3, 0) == 0) begin
        hq = 1'b1;
        hw = 1'b1;
        ha = 8'(m_addr);
      end
      rv = $urandom_range(19, 0);
      if (rv < 12)      rerr = 2'b00;
      else if (rv < 17) rerr = 2'b01;
      else if (rv < 19) rerr = 2'b10;
      else              rerr = 2'b11;
      step(r, en, hq, hw, ha, rerr, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ecc_scrub_ctrl.md
ECC_SCRUB_CTRL -- requirements
Module: ecc_scrub_ctrl

Interface
REQ-001 Parameter BANK_SIZE, default 256, number of words in the SECDED-protected bank; AW = $clog2(BANK_SIZE).
REQ-002 Parameter SCRUB_INTERVAL, default 1024, cycles between scrub starts, >=2.
REQ-003 Parameter STALL_LIMIT, default 16, consecutive host-blocked cycles before the scrubber forces port ownership, >=1.
REQ-004 clk_i  in  1  clock, all logic on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 scrub_en_i  in  1  enables background scrubbing.
REQ-007 host_req_i  in  1  host TCDM request to the bank.
REQ-008 host_we_i  in  1  host write enable, active-high.
REQ-009 host_add_i  in  AW  host word address.
REQ-010 host_gnt_o  out  1  host grant; host request is accepted only when high.
REQ-011 bank_req_o  out  1  bank request.
REQ-012 bank_we_o  out  1  bank write enable.
REQ-013 bank_add_o  out  AW  bank word address.
REQ-014 scrub_sel_o  out  1  high: external mux drives bank write data from scrub_wdata_o, all byte enables set.
REQ-015 scrub_wdata_o  out  32  corrected data for write-back, to external SECDED encoder.
REQ-016 dec_data_i  in  32  decoder output of bank read data.
REQ-017 dec_err_i  in  2  decoder error flags: [0] single (correctable), [1] double (uncorrectable).
REQ-018 corr_cnt_o  out  16  corrected-error count, saturating.
REQ-019 uncorr_cnt_o  out  16  uncorrectable-error count, saturating.
REQ-020 uncorr_o  out  1  one-cycle pulse on uncorrectable error; uncorr_add_o valid same cycle.
REQ-021 uncorr_add_o  out  AW  address of last uncorrectable error.

Function
REQ-022 FSM states IDLE, READ, CHECK, WRITE.
REQ-023 Interval counter reloads SCRUB_INTERVAL-1 while scrub_en_i low or on leaving CHECK/WRITE; decrements in IDLE; IDLE->READ when it reaches 0 with scrub_en_i high.
REQ-024 When scrub logic does not own the port: host_gnt_o=1, bank_req_o=host_req_i, bank_we_o=host_we_i, bank_add_o=host_add_i, scrub_sel_o=0.
REQ-025 READ with host_req_i=0: issue bank_req_o=1, bank_we_o=0, bank_add_o=scrub address; go CHECK; stall counter cleared.
REQ-026 READ with host_req_i=1: host served, stall counter increments; stay READ.
REQ-027 READ with stall counter = STALL_LIMIT: issue scrub read regardless, host_gnt_o=0, go CHECK.
REQ-028 CHECK: host owns port; dec_err_i sampled; dec_data_i captured into scrub_wdata_o register.
REQ-029 CHECK, dec_err_i[1]=1: uncorr_o pulse, uncorr_add_o=scrub address, uncorr_cnt_o+1, go IDLE; no write-back.
REQ-030 CHECK, dec_err_i=2'b01: corr_cnt_o+1, go WRITE; unless host writes the scrub address in that cycle (write-back cancelled, count still incremented, go IDLE).
REQ-031 CHECK, dec_err_i=2'b00: go IDLE.
REQ-032 WRITE: single cycle, bank_req_o=1, bank_we_o=1, bank_add_o=scrub address, scrub_sel_o=1, host_gnt_o=0; go IDLE.
REQ-033 Scrub address increments when leaving CHECK to IDLE or leaving WRITE; wraps BANK_SIZE-1 -> 0.
REQ-034 Counters saturate at 16'hFFFF, no wrap.
REQ-035 scrub_en_i deasserted mid-sequence: current READ/CHECK/WRITE completes; no new READ entered.
REQ-036 Scrub-to-write-back latency: READ issue at t, WRITE at t+2.

Reset
REQ-037 rst_i high at a rising edge: state IDLE, scrub address 0, interval counter SCRUB_INTERVAL-1, stall counter 0, counters 0, scrub_wdata_o 0, uncorr_add_o 0, uncorr_o 0; outputs pass host through (host_gnt_o=1, scrub_sel_o=0).
REQ-038 Reset mid-sequence aborts it; no write-back issued after reset.

Verification
REQ-039 SCRUB_INTERVAL=4, host idle, no errors: reads at address 0,1,2,... every 6 cycles; addresses wrap 255->0; counters stay 0.
REQ-040 dec_err_i=2'b01, dec_data_i=32'hDEADBEEF in CHECK: WRITE next cycle, bank_we_o=1, scrub_sel_o=1, scrub_wdata_o=32'hDEADBEEF, host_gnt_o=0, corr_cnt_o=1.
REQ-041 dec_err_i=2'b10 at address 5: uncorr_o one-cycle pulse, uncorr_add_o=5, uncorr_cnt_o=1, no bank write.
REQ-042 STALL_LIMIT=3, host_req_i held high: host granted 3 cycles, 4th cycle host_gnt_o=0 and scrub read issued.
REQ-043 Host write to scrub address during CHECK with single error: no WRITE state, corr_cnt_o=1, address advances.
REQ-044 Counter preloaded to 16'hFFFF plus another single error -> stays 16'hFFFF; rst_i asserted in CHECK -> no write-back, all outputs at reset values.
